// File: rtl/branch_resolver_pkg.sv
// Shared opcodes, resolver state encoding and RV32 immediate decoders
// for the execute-stage branch resolution path.
package branch_resolver_pkg;

  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    BR_IDLE     = 2'd0,
    BR_REDIRECT = 2'd1,
    BR_DRAIN    = 2'd2
  } br_state_e;

  function automatic logic [31:0] jimm(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] bimm(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational architectural next-PC computation for the EX instruction,
// plus a flag marking control-flow opcodes.
module branch_target_calc
  import branch_resolver_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic        i_taken,
  input  logic [31:0] i_jalr_target,
  output logic [31:0] o_actual_pc,
  output logic        o_is_cf
);

  logic [31:0] w_seq_pc;

  assign w_seq_pc = i_pc + 32'd4;

  // Select the next PC by opcode; unknown opcodes fall through sequentially
  always_comb begin
    o_actual_pc = w_seq_pc;
    o_is_cf     = 1'b0;
    case (i_instr[6:0])
      OPCODE_JAL: begin
        o_actual_pc = i_pc + jimm(i_instr);
        o_is_cf     = 1'b1;
      end
      OPCODE_BRANCH: begin
        if (i_taken) begin
          o_actual_pc = i_pc + bimm(i_instr);
        end else begin
          o_actual_pc = w_seq_pc;
        end
        o_is_cf = 1'b1;
      end
      OPCODE_JALR: begin
        o_actual_pc = i_jalr_target & ~32'd1;
        o_is_cf     = 1'b1;
      end
      default: begin
        o_actual_pc = w_seq_pc;
        o_is_cf     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves control flow in EX, issues a registered redirect to fetch on
// mispredict, squashes IF/ID during redirect/drain and keeps perf counters.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [31:0]      ex_instr,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_predicted_pc,
  input  logic             ex_taken,
  input  logic [31:0]      ex_jalr_target,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic             flush,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_mispredicts
);

  localparam logic [2:0]       FLUSH_LD = 3'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  br_state_e        r_state;
  logic             r_redirect_valid;
  logic [31:0]      r_redirect_pc;
  logic             r_flush;
  logic [2:0]       r_drain_cnt;
  logic [CNT_W-1:0] r_perf_br;
  logic [CNT_W-1:0] r_perf_mis;

  logic [31:0] w_actual;
  logic        w_is_cf;
  logic        w_resolve;
  logic        w_mispredict;

  branch_target_calc u_calc (
    .i_instr       (ex_instr),
    .i_pc          (ex_pc),
    .i_taken       (ex_taken),
    .i_jalr_target (ex_jalr_target),
    .o_actual_pc   (w_actual),
    .o_is_cf       (w_is_cf)
  );

  // EX contents are only trusted while idle; redirect/drain cycles are wrong-path
  assign w_resolve    = ex_valid && (r_state == BR_IDLE);
  assign w_mispredict = w_resolve && (w_actual != ex_predicted_pc);

  // Redirect FSM with registered handshake outputs and drain counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= BR_IDLE;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
      r_flush          <= 1'b0;
      r_drain_cnt      <= 3'd0;
    end else begin
      case (r_state)
        BR_IDLE: begin
          if (w_mispredict) begin
            r_redirect_pc    <= w_actual;
            r_redirect_valid <= 1'b1;
            r_flush          <= 1'b1;
            r_state          <= BR_REDIRECT;
          end
        end
        BR_REDIRECT: begin
          if (redirect_ready) begin
            r_redirect_valid <= 1'b0;
            if (FLUSH_CYCLES == 0) begin
              r_flush <= 1'b0;
              r_state <= BR_IDLE;
            end else begin
              r_drain_cnt <= FLUSH_LD;
              r_state     <= BR_DRAIN;
            end
          end
        end
        BR_DRAIN: begin
          if (r_drain_cnt <= 3'd1) begin
            r_flush     <= 1'b0;
            r_drain_cnt <= 3'd0;
            r_state     <= BR_IDLE;
          end else begin
            r_drain_cnt <= r_drain_cnt - 3'd1;
          end
        end
        default: begin
          r_state          <= BR_IDLE;
          r_redirect_valid <= 1'b0;
          r_flush          <= 1'b0;
          r_drain_cnt      <= 3'd0;
        end
      endcase
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_br  <= '0;
      r_perf_mis <= '0;
    end else begin
      if (w_resolve && w_is_cf && (r_perf_br != CNT_MAX)) begin
        r_perf_br <= r_perf_br + CNT_W'(1);
      end
      if (w_mispredict && (r_perf_mis != CNT_MAX)) begin
        r_perf_mis <= r_perf_mis + CNT_W'(1);
      end
    end
  end

  assign redirect_valid   = r_redirect_valid;
  assign redirect_pc      = r_redirect_pc;
  assign flush            = r_flush;
  assign perf_branches    = r_perf_br;
  assign perf_mispredicts = r_perf_mis;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: a 32-bit counter instance and a
// 4-bit counter instance share stimulus; a monitor checks every redirect.
module tb_branch_resolver;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_instr;
  logic [31:0] ex_pc;
  logic [31:0] ex_predicted_pc;
  logic        ex_taken;
  logic [31:0] ex_jalr_target;
  logic        redirect_ready;

  logic        a_valid, b_valid, a_flush, b_flush;
  logic [31:0] a_pc, b_pc;
  logic [31:0] a_br, a_mis;
  logic [3:0]  b_br, b_mis;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] I_BEQ_P20 = 32'h0200_0063;
  localparam logic [31:0] I_BEQ_M10 = 32'hFE00_08E3;
  localparam logic [31:0] I_JAL_P8  = 32'h0080_006F;
  localparam logic [31:0] I_JALR    = 32'h0000_8067;
  localparam logic [31:0] I_ADDI    = 32'h0000_0013;

  branch_resolver #(.FLUSH_CYCLES(2), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_instr(ex_instr),
    .ex_pc(ex_pc), .ex_predicted_pc(ex_predicted_pc), .ex_taken(ex_taken),
    .ex_jalr_target(ex_jalr_target), .redirect_valid(a_valid),
    .redirect_pc(a_pc), .redirect_ready(redirect_ready), .flush(a_flush),
    .perf_branches(a_br), .perf_mispredicts(a_mis)
  );

  branch_resolver #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_instr(ex_instr),
    .ex_pc(ex_pc), .ex_predicted_pc(ex_predicted_pc), .ex_taken(ex_taken),
    .ex_jalr_target(ex_jalr_target), .redirect_valid(b_valid),
    .redirect_pc(b_pc), .redirect_ready(redirect_ready), .flush(b_flush),
    .perf_branches(b_br), .perf_mispredicts(b_mis)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one EX instruction for a single resolving edge
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] pred, input logic taken,
                       input logic [31:0] jt, input logic exp_redir,
                       input logic [31:0] exp_pc);
    ex_valid = 1'b1; ex_instr = instr; ex_pc = pc; ex_predicted_pc = pred;
    ex_taken = taken; ex_jalr_target = jt;
    if (exp_redir) exp_q.push_back(exp_pc);
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  // Accept the pending redirect and wait (bounded) for the drain to finish
  task automatic wait_idle();
    redirect_ready = 1'b1;
    for (int k = 0; k < 8 && (a_valid || a_flush); k++) begin
      @(posedge clk); #1;
      redirect_ready = 1'b0;
    end
    redirect_ready = 1'b0;
    check("idle_flush", {31'd0, a_flush}, 32'd0);
  endtask

  // Monitor: every cycle a redirect is shown, compare against the queue head
  always @(negedge clk) begin
    if (rst_n && (a_valid || b_valid)) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_mis++;
        $display("FAIL unexpected_redirect: got pc 0x%08h expected none", a_pc);
      end else begin
        check("redirect_pc_a", a_pc, exp_q[0]);
        check("redirect_pc_b", b_pc, exp_q[0]);
        check("redirect_valid_b", {31'd0, b_valid}, 32'd1);
        if (redirect_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_instr = 32'd0; ex_pc = 32'd0;
    ex_predicted_pc = 32'd0; ex_taken = 1'b0; ex_jalr_target = 32'd0;
    redirect_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, a_valid}, 32'd0);
    check("rst_flush", {31'd0, a_flush}, 32'd0);
    check("rst_pc", a_pc, 32'd0);
    check("rst_br", a_br, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: backward taken branch predicted correctly
    issue(I_BEQ_M10, 32'h200, 32'h1F0, 1'b1, 32'd0, 1'b0, 32'd0);
    check("t1_valid", {31'd0, a_valid}, 32'd0);
    check("t1_flush", {31'd0, a_flush}, 32'd0);
    check("t1_br", a_br, 32'd1);
    check("t1_mis", a_mis, 32'd0);

    // 2: forward taken branch predicted not-taken, immediate accept
    issue(I_BEQ_P20, 32'h100, 32'h104, 1'b1, 32'd0, 1'b1, 32'h120);
    check("t2_valid", {31'd0, a_valid}, 32'd1);
    check("t2_flush", {31'd0, a_flush}, 32'd1);
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    check("t2_hs_valid", {31'd0, a_valid}, 32'd0);
    check("t2_drain1", {31'd0, a_flush}, 32'd1);
    @(posedge clk); #1;
    check("t2_drain2", {31'd0, a_flush}, 32'd1);
    @(posedge clk); #1;
    check("t2_idle", {31'd0, a_flush}, 32'd0);
    check("t2_br", a_br, 32'd2);
    check("t2_mis", a_mis, 32'd1);

    // 3+4: JALR clears bit 0; ready held low while wrong-path EX mismatches
    issue(I_JALR, 32'h1000, 32'h2004, 1'b0, 32'h2003, 1'b1, 32'h2002);
    for (int i = 0; i < 3; i++) begin
      ex_valid = 1'b1; ex_instr = I_ADDI; ex_pc = 32'h500; ex_predicted_pc = 32'h999;
      @(posedge clk); #1;
      check("t4_hold_valid", {31'd0, a_valid}, 32'd1);
    end
    check("t4_br_hold", a_br, 32'd3);
    check("t4_mis_hold", a_mis, 32'd2);
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    check("t4_hs_valid", {31'd0, a_valid}, 32'd0);
    @(posedge clk); #1;
    check("t4_drain", {31'd0, a_flush}, 32'd1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    check("t4_idle", {31'd0, a_flush}, 32'd0);
    check("t4_br", a_br, 32'd3);
    check("t4_mis", a_mis, 32'd2);

    // Not-taken branch correct; defensive mismatch on a plain ALU op
    issue(I_BEQ_P20, 32'h600, 32'h604, 1'b0, 32'd0, 1'b0, 32'd0);
    check("nt_br", a_br, 32'd4);
    issue(I_ADDI, 32'h40, 32'h48, 1'b0, 32'd0, 1'b1, 32'h44);
    wait_idle();
    check("alu_br", a_br, 32'd4);
    check("alu_mis", a_mis, 32'd3);

    // 5: asynchronous reset during REDIRECT discards the redirect
    issue(I_JAL_P8, 32'h3000, 32'h3004, 1'b0, 32'd0, 1'b1, 32'h3008);
    check("t5_pre_valid", {31'd0, a_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("t5_rst_valid", {31'd0, a_valid}, 32'd0);
    check("t5_rst_flush", {31'd0, a_flush}, 32'd0);
    check("t5_rst_pc", a_pc, 32'd0);
    check("t5_rst_br", a_br, 32'd0);
    check("t5_rst_mis", a_mis, 32'd0);
    check("t5_rst_b_valid", {31'd0, b_valid}, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(I_JAL_P8, 32'h3000, 32'h3008, 1'b0, 32'd0, 1'b0, 32'd0);
    check("t5_jal_valid", {31'd0, a_valid}, 32'd0);
    check("t5_jal_br", a_br, 32'd1);
    check("t5_jal_mis", a_mis, 32'd0);

    // 6: twenty mispredicts saturate the 4-bit counters
    for (int i = 0; i < 20; i++) begin
      issue(I_BEQ_P20, 32'h100, 32'h104, 1'b1, 32'd0, 1'b1, 32'h120);
      wait_idle();
    end
    check("t6_a_br", a_br, 32'd21);
    check("t6_a_mis", a_mis, 32'd20);
    check("t6_b_br", {28'd0, b_br}, 32'h0000_000F);
    check("t6_b_mis", {28'd0, b_mis}, 32'h0000_000F);
    issue(I_BEQ_M10, 32'h200, 32'h1F0, 1'b1, 32'd0, 1'b0, 32'd0);
    check("t6_a_br2", a_br, 32'd22);
    check("t6_b_br_hold", {28'd0, b_br}, 32'h0000_000F);

    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Execute-stage branch resolution unit: the back end of the fetch-stage static prediction path. It computes the architecturally correct next PC of each control-flow instruction reaching EX and compares it with the PC that fetch actually followed. On a mismatch it issues a registered redirect to fetch over a valid/ready handshake and squashes the wrong-path instructions in IF/ID. It also keeps saturating branch and mispredict counters for performance analysis.

## Interface
Parameters:
- `FLUSH_CYCLES`, 2: cycles `flush` stays high after the redirect handshake (drain of in-flight wrong-path fetches); legal range 0..7.
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk`  in  1  the single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  EX holds a valid instruction this cycle.
- `ex_instr`  in  32  EX instruction word.
- `ex_pc`  in  32  PC of the EX instruction.
- `ex_predicted_pc`  in  32  next PC fetch used after this instruction, carried down the pipe.
- `ex_taken`  in  1  branch comparator result from the ALU; meaningful for BRANCH only.
- `ex_jalr_target`  in  32  rs1+imm from the ALU; meaningful for JALR only.
- `redirect_valid`  out  1  redirect request to fetch.
- `redirect_pc`  out  32  corrected PC; stable while `redirect_valid` is high.
- `redirect_ready`  in  1  fetch accepts the redirect.
- `flush`  out  1  squash IF/ID (insert bubbles).
- `perf_branches`  out  CNT_W  resolved control-flow instructions.
- `perf_mispredicts`  out  CNT_W  resolved mispredictions.

## Operation
- Actual next PC (all arithmetic mod 2^32):
  - JAL: `ex_pc + Jimm`.
  - BRANCH: `ex_pc + Bimm` if `ex_taken`, else `ex_pc + 4`.
  - JALR: `ex_jalr_target & ~1`.
  - Every other opcode: `ex_pc + 4`.
- Jimm and Bimm use the standard RV32 immediate layouts, sign-extended, bit 0 zero.
- `resolve = ex_valid && state==IDLE`.
- `mispredict = resolve && actual != ex_predicted_pc`. This applies to non-control opcodes as well, as a defensive check.
- State machine:
  - IDLE: outputs low. On `mispredict`, latch `actual` into `redirect_pc` and go to REDIRECT.
  - REDIRECT: `redirect_valid=1`, `flush=1`. On `redirect_ready`, go to DRAIN, or to IDLE if FLUSH_CYCLES==0.
  - DRAIN: `flush=1`. A down-counter is loaded with FLUSH_CYCLES on the handshake and decremented each cycle. Go to IDLE in the cycle the counter reaches 1.
- In REDIRECT and DRAIN, EX contents are wrong-path: they are never evaluated or counted, and a mismatch does not re-trigger.
- Counters:
  - `perf_branches` increments on `resolve` for JAL, JALR or BRANCH.
  - `perf_mispredicts` increments on `mispredict`, for any opcode.
  - Both saturate at all-ones and never wrap.
- Reset, including mid-REDIRECT or mid-DRAIN: state IDLE, `redirect_valid=0`, `redirect_pc=0`, `flush=0`, both counters 0, drain counter 0. A pending redirect is discarded.

## Timing
- Mispredict resolved in EX cycle N: `redirect_valid` and `flush` go high in cycle N+1, driven directly from registers.
- Handshake completes on any rising edge with `redirect_valid && redirect_ready`. `redirect_pc` must not change while valid is high and ready is low.
- After a handshake in cycle M, `flush` stays high for cycles M+1 .. M+FLUSH_CYCLES. IDLE is reached at M+FLUSH_CYCLES+1.
- The earliest next resolution is in cycle M+FLUSH_CYCLES+1.
- Counters update on the edge ending the resolving cycle, visible one cycle later.
- No combinational path from `redirect_ready` to any output.

## Structure
- `rtl/Defines.v` (shared) already holds `OPCODE_JAL` and `OPCODE_BRANCH`. Add `OPCODE_JALR` and state encodings `BR_IDLE`, `BR_REDIRECT`, `BR_DRAIN` (2 bits) there.
- One combinational sub-module, `branch_target_calc`:
  - inputs: instr, pc, taken, jalr_target;
  - outputs: actual next PC and an `is_cf` flag.
- FSM, drain counter and saturating counters stay in `branch_resolver`.

## Test plan
1. Backward BRANCH at 0x200, Bimm=-0x10, taken, predicted 0x1F0 -> no redirect, `flush` stays 0, branches=1, mispredicts=0.
2. Forward BRANCH at 0x100, Bimm=+0x20, taken, predicted 0x104 -> next cycle `redirect_valid=1`, `redirect_pc=0x120`, `flush=1`. Ready high -> `flush` high 2 more cycles, then IDLE; mispredicts=1.
3. JALR with `ex_jalr_target=0x2003`, predicted 0x2004 -> `redirect_pc=0x2002`.
4. Hold `redirect_ready` low 3 cycles while EX presents mismatching wrong-path instructions -> `redirect_pc` stable, counters unchanged, single handshake on cycle 4.
5. Assert `rst_n` low during REDIRECT -> all outputs 0 immediately (asynchronously). After release, a matching JAL resolves normally.
6. CNT_W=4: 20 consecutive mispredicted BRANCHes, each followed by drain -> both counters saturate at 0xF and hold.
